// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Arbitrates two requesters onto one HD44780-style character-LCD write port.
//   After reset it waits for the LCD power-up time and then sends the fixed
//   init sequence (0x38, 0x0C, 0x01, 0x06 as commands) by itself. Once that
//   is done it grants requesters round-robin. Every write goes through
//   SETUP (EN low), PULSE (EN high), HOLD (EN low) and an execution wait. The
//   execution wait is longer for the clear (0x01) and home (0x02) commands.
//
//   Build option: define LCD_ARB_FIXED_PRIO_EN to make requester 0 always win
//   when both requesters are valid. This build has no round-robin pointer.
//
// Ports:
//   CLOCK_50                 system clock (50 MHz)
//   reset                    synchronous, active-high reset
//   req0_valid/rs/data       requester 0 write request: RS (0 cmd, 1 data) + byte
//   req0_ready               requester 0 write accepted this cycle (combinational)
//   req1_*                   same as req0_*, for requester 1
//   LCD_RS/LCD_RW/LCD_EN     LCD control pins (LCD_RW is always 0 = write)
//   LCD_DATA                 LCD data bus
//   busy                     high whenever the sequencer is not idle
//   init_done                high once the init sequence has completed
//   grant_id                 requester of the most recently accepted write
module lcd_write_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int EN_CYC      = 12,
  parameter int HOLD_CYC    = 2,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int POWERUP_CYC = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA,
  output logic       busy,
  output logic       init_done,
  output logic       grant_id
);

  localparam int MAX_CYC = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter reload values: a state of length N loads N-1 and leaves at zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC_WAIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       init_idx, init_idx_next;
  logic             init_done_next;
  logic             rs_next;
  logic [7:0]       data_next;
  logic             grant_next;
  logic             winner;
  logic             can_accept;
  logic             accept;
  logic             cnt_zero;
  logic             is_clear;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_byte = 8'h0C;  // display on, cursor off
      2'd2:    init_byte = 8'h01;  // clear display
      default: init_byte = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

`ifdef LCD_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid.
  assign winner = ~req0_valid;
`else
  logic ptr, ptr_next;
  // ptr names the requester that wins a tie; it always points away from the
  // last grant, so a tie goes to the requester not granted last.
  assign winner = (req0_valid & req1_valid) ? ptr : req1_valid;
`endif

  assign can_accept = (state == IDLE) & init_done;
  assign req0_ready = can_accept & ~winner & req0_valid;
  assign req1_ready = can_accept &  winner & req1_valid;
  assign accept     = req0_ready | req1_ready;

  assign cnt_zero = (cnt == '0);
  assign is_clear = ~LCD_RS & ((LCD_DATA == 8'h01) | (LCD_DATA == 8'h02));

  assign LCD_RW = 1'b0;
  assign LCD_EN = (state == PULSE);
  assign busy   = (state != IDLE);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    init_idx_next  = init_idx;
    init_done_next = init_done;
    rs_next        = LCD_RS;
    data_next      = LCD_DATA;
    grant_next     = grant_id;
`ifndef LCD_ARB_FIXED_PRIO_EN
    ptr_next       = ptr;
`endif

    // Every state except IDLE is timed by the one shared down-counter.
    if (state != IDLE && !cnt_zero) begin
      cnt_next = cnt - 1'b1;
    end

    case (state)
      PWR_WAIT: begin
        if (cnt_zero) begin
          state_next    = SETUP;
          cnt_next      = SETUP_LD;
          init_idx_next = 2'd0;
          rs_next       = 1'b0;
          data_next     = init_byte(2'd0);
        end
      end
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          cnt_next   = SETUP_LD;
          rs_next    = winner ? req1_rs : req0_rs;
          data_next  = winner ? req1_data : req0_data;
          grant_next = winner;
`ifndef LCD_ARB_FIXED_PRIO_EN
          ptr_next   = ~winner;
`endif
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_next = PULSE;
          cnt_next   = EN_LD;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_next = EXEC_WAIT;
          cnt_next   = is_clear ? CLEAR_LD : EXEC_LD;
        end
      end
      EXEC_WAIT: begin
        if (cnt_zero) begin
          if (init_done) begin
            state_next = IDLE;
          end else if (init_idx == 2'd3) begin
            state_next     = IDLE;
            init_done_next = 1'b1;
          end else begin
            state_next    = SETUP;
            cnt_next      = SETUP_LD;
            init_idx_next = init_idx + 2'd1;
            rs_next       = 1'b0;
            data_next     = init_byte(init_idx + 2'd1);
          end
        end
      end
      default: begin
        state_next = PWR_WAIT;
        cnt_next   = PWR_LD;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= PWR_WAIT;
      cnt       <= PWR_LD;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
      grant_id  <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
      ptr       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_idx  <= init_idx_next;
      init_done <= init_done_next;
      LCD_RS    <= rs_next;
      LCD_DATA  <= data_next;
      grant_id  <= grant_next;
`ifndef LCD_ARB_FIXED_PRIO_EN
      ptr       <= ptr_next;
`endif
    end
  end

endmodule
